hex_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for a bank of 7-segment digits sharing one hex->7seg decoder.

---
 rtl/hex_scan_controller.sv | 152 +++++++++++++++
 tb/tb_hex_scan_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// Time-multiplexed 7-segment scan controller: one shared hex decoder swept across NUM_DIGITS digits,
// with a blanked guard cycle between slots. Optional feature macro: LEADING_ZERO_BLANK_EN.
module hex_scan_controller #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                          CLOCK_50,
    input  logic                          RST,
    input  logic                          WR_EN,
    input  logic [$clog2(NUM_DIGITS)-1:0] WR_ADDR,
    input  logic [3:0]                    WR_DATA,
    input  logic [NUM_DIGITS-1:0]         BLANK_MASK,
    output logic [6:0]                    SEG,
    output logic [NUM_DIGITS-1:0]         DIG_SEL,
    output logic                          FRAME_DONE
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_SHOW = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [3:0]        digits_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;

    // Active-low segment pattern, bit 0 = a .. bit 6 = g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_OFF;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Digit storage; out-of-range addresses match no entry and are dropped
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digits_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (WR_EN && (WR_ADDR == IDX_W'(i))) begin
                    digits_q[i] <= WR_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q      <= S_DEAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Slot sequencing: one guard cycle, then SCAN_DIV show cycles for the current digit
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_DEAD: begin
                state_d = S_SHOW;
                cnt_d   = '0;
            end
            S_SHOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_DEAD;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Digit i>=1 is a leading zero when it and every more-significant digit hold 0
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (digits_q[i] == 4'h0);
            lz_blank[i] = upper_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Moore decode of the registered scan state; BLANK_MASK acts combinationally
    always_comb begin
        SEG     = SEG_OFF;
        DIG_SEL = '0;
        if (state_q == S_SHOW) begin
            DIG_SEL = NUM_DIGITS'(1) << idx_q;
            if (!(BLANK_MASK[idx_q] || lz_blank[idx_q])) begin
                SEG = hex_to_seg(digits_q[idx_q]);
            end
        end
    end

    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Scoreboard bench for hex_scan_controller: a 4-digit and a 3-digit instance share stimulus and are
// checked against a slot-arithmetic reference model (honours LEADING_ZERO_BLANK_EN when defined).
module tb_hex_scan_controller;

    localparam int SD = 4;
    localparam int SLOT = SD + 1;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [6:0] seg4;
        logic [3:0] dig4;
        logic       fd4;
        logic [6:0] seg3;
        logic [2:0] dig3;
        logic       fd3;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] blank_mask;
    logic [6:0] seg4, seg3;
    logic [3:0] dig4;
    logic [2:0] dig3;
    logic       fd4, fd3;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference state: cycles since reset release and the stored digit values
    int          t;
    logic [15:0] m4;
    logic [15:0] m3;

    hex_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(SD)) u_dut4 (
        .CLOCK_50(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .BLANK_MASK(blank_mask), .SEG(seg4), .DIG_SEL(dig4), .FRAME_DONE(fd4)
    );

    hex_scan_controller #(.NUM_DIGITS(3), .SCAN_DIV(SD)) u_dut3 (
        .CLOCK_50(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .BLANK_MASK(blank_mask[2:0]), .SEG(seg3), .DIG_SEL(dig3), .FRAME_DONE(fd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input int n, input logic [15:0] m, input logic [3:0] bm, input int tc);
        int pos;
        int d;
        pos = tc % SLOT;
        d   = (tc / SLOT) % n;
        if (pos == 0) return 7'h7F;
        if (bm[d]) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (d >= 1) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int j = d; j < n; j++) begin
                if (m[4*j +: 4] != 4'h0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h7F;
        end
`endif
        return SEG_TAB[m[4*d +: 4]];
    endfunction

    function automatic logic [3:0] model_dig(input int n, input int tc);
        if (tc % SLOT == 0) return 4'h0;
        return 4'(1 << ((tc / SLOT) % n));
    endfunction

    function automatic logic model_fd(input int n, input int tc);
        return (tc > 0) && (tc % SLOT == 0) && ((tc / SLOT) % n == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.seg4 = model_seg(4, m4, blank_mask, t);
        e.dig4 = model_dig(4, t);
        e.fd4  = model_fd(4, t);
        e.seg3 = model_seg(3, m3, {1'b0, blank_mask[2:0]}, t);
        e.dig3 = 3'(model_dig(3, t));
        e.fd3  = model_fd(3, t);
        q.push_back(e);
    endtask

    // One clock: commit the write presented last cycle, then drive new inputs and predict outputs
    task automatic step(input logic we, input logic [1:0] a, input logic [3:0] d, input logic [3:0] bm);
        @(posedge clk);
        if (wr_en) begin
            m4[4*wr_addr +: 4] = wr_data;
            if (wr_addr < 2'd3) m3[4*wr_addr +: 4] = wr_data;
        end
        t++;
        #1;
        wr_en      = we;
        wr_addr    = a;
        wr_data    = d;
        blank_mask = bm;
        push_expected();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        t       = 0;
        m4      = '0;
        m3      = '0;
        wr_en   = 1'b0;
        push_expected();
    endtask

    task automatic idle_until(input int pos_mod, input int frame_pos);
        for (int k = 0; k < 4 * SLOT + 1; k++) begin
            if ((t % pos_mod) == frame_pos) break;
            step(1'b0, 2'd0, 4'h0, 4'h0);
        end
    endtask

    // Monitor: outputs are present every cycle; compare mid-cycle against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seg4", 32'(seg4), 32'(e.seg4));
                chk("dig_sel4", 32'(dig4), 32'(e.dig4));
                chk("frame_done4", 32'(fd4), 32'(e.fd4));
                chk("seg3", 32'(seg3), 32'(e.seg3));
                chk("dig_sel3", 32'(dig3), 32'(e.dig3));
                chk("frame_done3", 32'(fd3), 32'(e.fd3));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        blank_mask = '0;
        t          = 0;
        m4         = '0;
        m3         = '0;
        #1;
        chk("reset_seg", 32'(seg4), 32'h7F);
        chk("reset_dig_sel", 32'(dig4), 32'h0);
        chk("reset_frame_done", 32'(fd4), 32'h0);
        repeat (2) @(posedge clk);
        release_reset();

        // Default values first, then 8,1,F,A to digits 0..3
        for (int k = 0; k < 2 * 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);
        step(1'b1, 2'd0, 4'h8, 4'h0);
        step(1'b1, 2'd1, 4'h1, 4'h0);
        step(1'b1, 2'd2, 4'hF, 4'h0);
        step(1'b1, 2'd3, 4'hA, 4'h0);
        for (int k = 0; k < 2 * 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);

        // Blank digit 2 for a frame; out-of-range address on the 3-digit instance
        for (int k = 0; k < 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'b0100);
        step(1'b1, 2'd3, 4'h7, 4'h0);
        for (int k = 0; k < 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);

        // Rewrite digit 2 in the middle of its slot
        idle_until(4 * SLOT, 2 * SLOT + 2);
        step(1'b1, 2'd2, 4'h3, 4'h0);
        for (int k = 0; k < 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);

        // Leading-zero pattern {0,0,5,0}
        step(1'b1, 2'd3, 4'h0, 4'h0);
        step(1'b1, 2'd2, 4'h0, 4'h0);
        step(1'b1, 2'd1, 4'h5, 4'h0);
        step(1'b1, 2'd0, 4'h0, 4'h0);
        for (int k = 0; k < 2 * 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);

        // Randomized writes and occasional blanking
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0, 2'($urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
        end

        // Asynchronous reset in the middle of a show slot
        idle_until(SLOT, 2);
        @(negedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("midreset_seg4", 32'(seg4), 32'h7F);
        chk("midreset_dig_sel4", 32'(dig4), 32'h0);
        chk("midreset_frame_done4", 32'(fd4), 32'h0);
        chk("midreset_dig_sel3", 32'(dig3), 32'h0);
        repeat (2) @(posedge clk);
        release_reset();
        for (int k = 0; k < 2 * 4 * SLOT; k++) step(1'b0, 2'd0, 4'h0, 4'h0);
        for (int k = 0; k < 100; k++) begin
            step($urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), 4'h0);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
